// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset release sequencer.
//   rst_seq_state_e : sequencer FSM state (2-bit encoding)
//   CAUSE_HW/CAUSE_SW : reset cause codes reported on last_cause
//   clog2_min1 / max_u : width helpers for parameter-derived counters
package rst_seq_pkg;

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StStretch = 2'd1,
    StRelease = 2'd2,
    StDone    = 2'd3
  } rst_seq_state_e;

  localparam logic [1:0] CAUSE_HW = 2'b01;
  localparam logic [1:0] CAUSE_SW = 2'b10;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Async-assert / sync-deassert reset synchronizer.
// A SYNC_STAGES flop chain preset by reset that shifts in 0 once reset drops.
//   clk      : destination clock
//   reset    : raw reset, active high, asynchronous
//   sync_rst : synchronized reset (last stage of the chain)
module reset_sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic sync_rst
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign sync_rst = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: asserts all rst_out bits asynchronously on reset,
// waits for the synchronized release, holds STRETCH_CYCLES, then releases
// rst_out[0..NUM_OUT-1] one every GAP_CYCLES. sw_rst_req re-runs the
// stretch/release part without the synchronizer.
//   clk        : clock
//   reset      : raw reset, async assert, active high
//   sw_rst_req : single-cycle software reset request (ignored in HOLD)
//   rst_out    : sequenced active-high resets, bit 0 releases first
//   rst_done   : all rst_out bits released
//   busy       : sequence in progress
//   last_cause : (only with RST_SEQ_CAUSE_EN) CAUSE_HW or CAUSE_SW
// Optional build macro: RST_SEQ_CAUSE_EN adds last_cause.
module reset_release_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned NUM_OUT        = 4,
  parameter int unsigned GAP_CYCLES     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               rst_done,
  output logic               busy
`ifdef RST_SEQ_CAUSE_EN
  ,
  output logic [1:0]         last_cause
`endif
);

  localparam int unsigned CntW = clog2_min1(max_u(STRETCH_CYCLES, GAP_CYCLES));
  localparam int unsigned IdxW = clog2_min1(NUM_OUT);
  localparam logic [CntW-1:0] StretchLoad = CntW'(STRETCH_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad     = CntW'(GAP_CYCLES - 1);
  localparam logic [IdxW-1:0] LastIdx     = IdxW'(NUM_OUT - 1);

  rst_seq_state_e     r_state, w_state_nxt;
  logic [CntW-1:0]    r_cnt, w_cnt_nxt;
  logic [IdxW-1:0]    r_idx, w_idx_nxt;
  logic [NUM_OUT-1:0] r_rst_out, w_rst_out_nxt;
  logic               w_sync_rst;
  logic               w_sw_ok;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .sync_rst(w_sync_rst)
  );

  // Software request only counts once the synchronized release has been seen.
  assign w_sw_ok = sw_rst_req && (r_state != StHold);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StHold;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_rst_out <= w_rst_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_rst_out_nxt = r_rst_out;

    unique case (r_state)
      StHold: begin
        if (!w_sync_rst) begin
          w_state_nxt = StStretch;
          w_cnt_nxt   = StretchLoad;
        end
      end
      StStretch: begin
        if (r_cnt == '0) begin
          w_rst_out_nxt[0] = 1'b0;
          if (NUM_OUT == 1) begin
            w_state_nxt = StDone;
          end else begin
            w_state_nxt = StRelease;
            w_idx_nxt   = IdxW'(1);
            w_cnt_nxt   = GapLoad;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      StRelease: begin
        if (r_cnt == '0) begin
          for (int i = 0; i < NUM_OUT; i++) begin
            if (r_idx == IdxW'(i)) w_rst_out_nxt[i] = 1'b0;
          end
          if (r_idx == LastIdx) begin
            w_state_nxt = StDone;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
            w_cnt_nxt = GapLoad;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      StDone: begin
        w_state_nxt = StDone;
      end
      default: begin
        w_state_nxt = StHold;
      end
    endcase

    // Software reset overrides normal progression in every non-HOLD state.
    if (w_sw_ok) begin
      w_rst_out_nxt = '1;
      w_state_nxt   = StStretch;
      w_cnt_nxt     = StretchLoad;
      w_idx_nxt     = '0;
    end
  end

  assign rst_out  = r_rst_out;
  assign rst_done = (r_state == StDone);
  assign busy     = (r_state != StDone);

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] r_cause;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cause <= CAUSE_HW;
    end else if (w_sw_ok) begin
      r_cause <= CAUSE_SW;
    end
  end

  assign last_cause = r_cause;
`endif

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Scoreboard bench for reset_release_sequencer: stimulus pushes the expected
// output transitions (edge number + values); monitors pop and compare every
// time the DUT outputs change. A second instance covers the 1-output corner.
module tb_reset_release_sequencer;

  typedef struct {
    int         e;
    logic [3:0] ro;
    logic       dn;
    logic       bz;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset2 = 1'b0;
  logic sw = 1'b0;
  logic sw2 = 1'b0;
  logic [3:0] rst_out;
  logic       rst_done, busy;
  logic [0:0] rst_out2;
  logic       rst_done2, busy2;
`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] cause, cause2;
`endif

  int   edge_n = 0;
  int   checks = 0;
  int   failures = 0;
  logic mon_arm = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  reset_release_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .sw_rst_req(sw),
    .rst_out   (rst_out),
    .rst_done  (rst_done),
    .busy      (busy)
`ifdef RST_SEQ_CAUSE_EN
    ,
    .last_cause(cause)
`endif
  );

  reset_release_sequencer #(
    .SYNC_STAGES   (3),
    .STRETCH_CYCLES(1),
    .NUM_OUT       (1),
    .GAP_CYCLES    (8)
  ) dut1 (
    .clk       (clk),
    .reset     (reset2),
    .sw_rst_req(sw2),
    .rst_out   (rst_out2),
    .rst_done  (rst_done2),
    .busy      (busy2)
`ifdef RST_SEQ_CAUSE_EN
    ,
    .last_cause(cause2)
`endif
  );

  // Monitors: any change of {rst_out, rst_done, busy} must match the next entry.
  logic [5:0] prev0, obs0, prev1, obs1;
  exp_t x0, x1;

  always @(negedge clk) begin
    obs0 = {rst_out, rst_done, busy};
    if (mon_arm && obs0 !== prev0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL dut0_unexpected_change edge=%0d got=%b", edge_n, obs0);
      end else begin
        x0 = q0.pop_front();
        if (x0.e != edge_n || obs0 !== {x0.ro, x0.dn, x0.bz}) begin
          failures++;
          $display("FAIL dut0_transition got edge=%0d out=%b want edge=%0d out=%b",
                   edge_n, obs0, x0.e, {x0.ro, x0.dn, x0.bz});
        end
      end
    end
    prev0 = obs0;
  end

  always @(negedge clk) begin
    obs1 = {3'b000, rst_out2, rst_done2, busy2};
    if (mon_arm && obs1 !== prev1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL dut1_unexpected_change edge=%0d got=%b", edge_n, obs1);
      end else begin
        x1 = q1.pop_front();
        if (x1.e != edge_n || obs1 !== {x1.ro, x1.dn, x1.bz}) begin
          failures++;
          $display("FAIL dut1_transition got edge=%0d out=%b want edge=%0d out=%b",
                   edge_n, obs1, x1.e, {x1.ro, x1.dn, x1.bz});
        end
      end
    end
    prev1 = obs1;
  end

  task automatic push0(input int e, input logic [3:0] ro, input logic dn, input logic bz);
    exp_t x;
    x.e = e; x.ro = ro; x.dn = dn; x.bz = bz;
    q0.push_back(x);
  endtask

  // Full release train with bit 0 falling at edge f.
  task automatic push_seq(input int f);
    push0(f,      4'b1110, 1'b0, 1'b1);
    push0(f + 8,  4'b1100, 1'b0, 1'b1);
    push0(f + 16, 4'b1000, 1'b0, 1'b1);
    push0(f + 24, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // Returns at posedge+1 of edge t (bounded).
  task automatic wait_edge(input int t);
    int n;
    n = 0;
    while (edge_n < t && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (edge_n < t) begin
      checks++;
      failures++;
      $display("FAIL wait_edge timeout at=%0d want=%0d", edge_n, t);
    end
  endtask

  int a, b, b2, e;

  initial begin
    // Reset state
    #1 reset = 1'b1; reset2 = 1'b1;
    wait_edge(5);
    chk("rst_out_reset", rst_out, 4'b1111);
    chk("rst_done_reset", {3'b0, rst_done}, 4'd0);
    chk("busy_reset", {3'b0, busy}, 4'd1);
    chk("rst_out2_reset", {3'b0, rst_out2}, 4'd1);
    chk("busy2_reset", {3'b0, busy2}, 4'd1);
`ifdef RST_SEQ_CAUSE_EN
    chk("cause_reset", {2'b0, cause}, 4'b0001);
`endif
    mon_arm = 1'b1;

    // Scenarios 1 and 6: release both resets between edges
    #1;
    b = edge_n;
    reset = 1'b0; reset2 = 1'b0;
    push_seq(b + 19);
    q1.push_back('{e: b + 5, ro: 4'b0000, dn: 1'b1, bz: 1'b0});
    wait_edge(b + 46);

    // Scenario 2: software request from DONE
    #1;
    e = edge_n + 1;
    sw = 1'b1;
    push0(e, 4'b1111, 1'b0, 1'b1);
    push_seq(e + 16);
    wait_edge(e);
    #1 sw = 1'b0;
`ifdef RST_SEQ_CAUSE_EN
    chk("cause_sw", {2'b0, cause}, 4'b0010);
`endif
    wait_edge(e + 44);

    // Scenario 4: software request at edge 25, after bit 0 released
    #1;
    a = edge_n;
    reset = 1'b1;
    push0(a, 4'b1111, 1'b0, 1'b1);
`ifdef RST_SEQ_CAUSE_EN
    #1 chk("cause_hw", {2'b0, cause}, 4'b0001);
`endif
    wait_edge(a + 3);
    #1;
    b = edge_n;
    reset = 1'b0;
    push0(b + 19, 4'b1110, 1'b0, 1'b1);
    push0(b + 25, 4'b1111, 1'b0, 1'b1);
    push_seq(b + 41);
    wait_edge(b + 24);
    #1 sw = 1'b1;
    wait_edge(b + 25);
    #1 sw = 1'b0;
    wait_edge(b + 68);

    // Scenario 3: async reset 0.3 period after edge 30
    #1;
    a = edge_n;
    reset = 1'b1;
    push0(a, 4'b1111, 1'b0, 1'b1);
    wait_edge(a + 3);
    #1;
    b = edge_n;
    reset = 1'b0;
    push0(b + 19, 4'b1110, 1'b0, 1'b1);
    push0(b + 27, 4'b1100, 1'b0, 1'b1);
    push0(b + 30, 4'b1111, 1'b0, 1'b1);
    wait_edge(b + 30);
    #2 reset = 1'b1;
    #1 chk("async_assert_rst_out", rst_out, 4'b1111);
    chk("async_assert_busy", {3'b0, busy}, 4'd1);
    wait_edge(b + 32);
    #1;
    b2 = edge_n;
    reset = 1'b0;
    push_seq(b2 + 19);
    wait_edge(b2 + 46);

    // Scenario 5: software request held through HOLD is ignored
    #1;
    a = edge_n;
    reset = 1'b1;
    push0(a, 4'b1111, 1'b0, 1'b1);
    wait_edge(a + 3);
    #1;
    b = edge_n;
    reset = 1'b0;
    sw = 1'b1;
    push_seq(b + 19);
    wait_edge(b + 3);
    #1 sw = 1'b0;
    wait_edge(b + 46);

    chk("q0_drained", 4'(q0.size()), 4'd0);
    chk("q1_drained", 4'(q1.size()), 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
